// File: rtl/vga_console_pkg.sv
// Shared constants, control codes and FSM encoding for the VGA text console writer.
package vga_console_pkg;

    localparam int COLS_DEF       = 12;
    localparam int ROWS_DEF       = 3;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam logic [6:0] CHAR_SPACE     = 7'h20;
    localparam logic [7:0] ASCII_LF       = 8'h0A;
    localparam logic [7:0] ASCII_CR       = 8'h0D;
    localparam logic [7:0] ASCII_BS       = 8'h08;
    localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
    localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_SCROLL_COPY = 2'd1,
        ST_SCROLL_FILL = 2'd2,
        ST_CLEAR       = 2'd3
    } state_e;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= ASCII_PRINT_LO) && (b <= ASCII_PRINT_HI);
    endfunction

endpackage

// File: rtl/console_byte_fifo.sv
// Small synchronous byte FIFO with first-word fall-through read data.
// DEPTH must be a power of two (pointers wrap naturally) and at least 2.
module console_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [AW:0]   count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign pop_data  = mem_r[rptr_r];

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wptr_r] <= push_data;
        end
    end

    // Pointers and occupancy count; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            count_r <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wptr_r <= wptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rptr_r <= rptr_r + AW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1'b1);
                2'b01:   count_r <= count_r - (AW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/vga_console_writer.sv
// Byte-stream front end of the VGA text console: decodes queued ASCII bytes into text RAM
// writes, tracks the cursor, and runs scroll and full-screen clear sequences.
module vga_console_writer
    import vga_console_pkg::*;
#(
    parameter int COLS       = COLS_DEF,
    parameter int ROWS       = ROWS_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    input  logic       clear_req,
    output logic       text_we,
    output logic [5:0] text_waddr,
    output logic [6:0] text_wdata,
    output logic [5:0] text_raddr,
    input  logic [6:0] text_rdata,
    output logic [5:0] cursor,
    output logic       busy
);

    localparam int         CELLS     = COLS * ROWS;
    localparam logic [5:0] LAST_CELL = 6'(CELLS - 1);
    localparam logic [5:0] LAST_COL  = 6'(COLS - 1);
    localparam logic [5:0] LAST_ROW  = 6'(ROWS - 1);
    localparam logic [5:0] COLS_W    = 6'(COLS);
    localparam logic [5:0] COPY_LAST = 6'((ROWS - 1) * COLS - 1);

    state_e     state_r;
    state_e     state_nx_s;
    logic [5:0] row_r;
    logic [5:0] col_r;
    logic [5:0] idx_r;
    logic       clear_pending_r;
    logic [5:0] row_nx_s;
    logic [5:0] col_nx_s;
    logic [5:0] idx_nx_s;
    logic       clear_pending_nx_s;
    logic       we_nx_s;
    logic [5:0] waddr_nx_s;
    logic [6:0] wdata_nx_s;

    logic       fifo_pop_s;
    logic [7:0] fifo_rdata_s;
    logic       fifo_full_s;
    logic       fifo_empty_s;

    logic       is_print_s;
    logic       is_lf_s;
    logic       is_cr_s;
    logic       is_bs_s;
    logic       at_last_col_s;
    logic       at_last_row_s;
    logic       scroll_trig_s;

    console_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_rdata_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign wr_ready = ~fifo_full_s;
    assign cursor   = row_r * COLS_W + col_r;
    // text_we is included so busy stays high through the final write cycle.
    assign busy     = (state_r != ST_IDLE) | ~fifo_empty_s | clear_pending_r | text_we;

    assign is_print_s    = is_printable(fifo_rdata_s);
    assign is_lf_s       = (fifo_rdata_s == ASCII_LF);
    assign is_cr_s       = (fifo_rdata_s == ASCII_CR);
    assign is_bs_s       = (fifo_rdata_s == ASCII_BS);
    assign at_last_col_s = (col_r == LAST_COL);
    assign at_last_row_s = (row_r == LAST_ROW);
    assign scroll_trig_s = at_last_row_s & ((is_print_s & at_last_col_s) | is_lf_s);

    // Scroll source read is one row ahead of the destination being written.
    assign text_raddr = (state_r == ST_SCROLL_COPY) ? (idx_r + COLS_W) : 6'd0;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; a pending clear wins over queued bytes.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (clear_pending_r) begin
                    state_nx_s = ST_CLEAR;
                end else if (!fifo_empty_s && scroll_trig_s) begin
                    state_nx_s = ST_SCROLL_COPY;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SCROLL_COPY: begin
                if (idx_r == COPY_LAST) begin
                    state_nx_s = ST_SCROLL_FILL;
                end else begin
                    state_nx_s = ST_SCROLL_COPY;
                end
            end
            ST_SCROLL_FILL, ST_CLEAR: begin
                if (idx_r == LAST_CELL) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM output logic: byte decode, cursor update and next write-port values.
    always_comb begin
        row_nx_s           = row_r;
        col_nx_s           = col_r;
        idx_nx_s           = idx_r;
        we_nx_s            = 1'b0;
        waddr_nx_s         = text_waddr;
        wdata_nx_s         = text_wdata;
        fifo_pop_s         = 1'b0;
        clear_pending_nx_s = clear_pending_r | clear_req;
        case (state_r)
            ST_IDLE: begin
                idx_nx_s = 6'd0;
                if (clear_pending_r) begin
                    clear_pending_nx_s = 1'b0;
                end else if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    if (is_print_s) begin
                        we_nx_s    = 1'b1;
                        waddr_nx_s = cursor;
                        wdata_nx_s = fifo_rdata_s[6:0];
                        if (at_last_col_s) begin
                            col_nx_s = 6'd0;
                            row_nx_s = at_last_row_s ? row_r : row_r + 6'd1;
                        end else begin
                            col_nx_s = col_r + 6'd1;
                        end
                    end else if (is_lf_s) begin
                        col_nx_s = 6'd0;
                        row_nx_s = at_last_row_s ? row_r : row_r + 6'd1;
                    end else if (is_cr_s) begin
                        col_nx_s = 6'd0;
                    end else if (is_bs_s) begin
                        if (col_r != 6'd0) begin
                            col_nx_s = col_r - 6'd1;
                        end else if (row_r != 6'd0) begin
                            row_nx_s = row_r - 6'd1;
                            col_nx_s = LAST_COL;
                        end else begin
                            col_nx_s = col_r;
                        end
                    end else begin
                        col_nx_s = col_r;
                    end
                end else begin
                    fifo_pop_s = 1'b0;
                end
            end
            ST_SCROLL_COPY: begin
                we_nx_s    = 1'b1;
                waddr_nx_s = idx_r;
                wdata_nx_s = text_rdata;
                idx_nx_s   = idx_r + 6'd1;
            end
            ST_SCROLL_FILL: begin
                we_nx_s    = 1'b1;
                waddr_nx_s = idx_r;
                wdata_nx_s = CHAR_SPACE;
                idx_nx_s   = idx_r + 6'd1;
            end
            ST_CLEAR: begin
                we_nx_s    = 1'b1;
                waddr_nx_s = idx_r;
                wdata_nx_s = CHAR_SPACE;
                idx_nx_s   = idx_r + 6'd1;
                if (idx_r == LAST_CELL) begin
                    row_nx_s = 6'd0;
                    col_nx_s = 6'd0;
                end else begin
                    row_nx_s = row_r;
                end
            end
            default: begin
                idx_nx_s = 6'd0;
            end
        endcase
    end

    // Cursor, sequence index, clear request latch and registered write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_r           <= 6'd0;
            col_r           <= 6'd0;
            idx_r           <= 6'd0;
            clear_pending_r <= 1'b1;
            text_we         <= 1'b0;
            text_waddr      <= 6'd0;
            text_wdata      <= 7'd0;
        end else begin
            row_r           <= row_nx_s;
            col_r           <= col_nx_s;
            idx_r           <= idx_nx_s;
            clear_pending_r <= clear_pending_nx_s;
            text_we         <= we_nx_s;
            text_waddr      <= waddr_nx_s;
            text_wdata      <= wdata_nx_s;
        end
    end

endmodule

// File: tb/tb_vga_console_writer.sv
// Directed bench for vga_console_writer: a screen/cursor model predicts the ordered write
// stream and final screen, with literal expectations for latency and boundary cases.
module tb_vga_console_writer;

    localparam int COLS  = 12;
    localparam int ROWS  = 3;
    localparam int CELLS = COLS * ROWS;

    logic       clk;
    logic       rst_n;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       clear_req;
    logic       text_we;
    logic [5:0] text_waddr;
    logic [6:0] text_wdata;
    logic [5:0] text_raddr;
    logic [6:0] text_rdata;
    logic [5:0] cursor;
    logic       busy;

    typedef struct packed {
        logic [5:0] addr;
        logic [6:0] data;
    } wr_t;

    logic [6:0] ram [64];
    logic       ram_fill;
    wr_t        exp_q [$];
    logic [6:0] mscr [CELLS];
    int         mcur;
    int         errors = 0;
    int         checks = 0;
    int         run_cur = 0;
    int         last_run = 0;

    vga_console_writer #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .clear_req  (clear_req),
        .text_we    (text_we),
        .text_waddr (text_waddr),
        .text_wdata (text_wdata),
        .text_raddr (text_raddr),
        .text_rdata (text_rdata),
        .cursor     (cursor),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Text RAM: combinational read, write on the clock edge.
    assign text_rdata = ram[text_raddr];
    always @(posedge clk) begin
        if (ram_fill) begin
            for (int i = 0; i < 64; i++) ram[i] <= 7'h00;
        end else if (text_we) begin
            ram[text_waddr] <= text_wdata;
        end
    end

    // Write-stream compare plus consecutive-write run tracking.
    always @(negedge clk) begin
        wr_t e;
        if (text_we === 1'b1) begin
            run_cur++;
        end else begin
            if (run_cur > 0) last_run = run_cur;
            run_cur = 0;
        end
        if (rst_n === 1'b1 && text_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: addr=%0d data=%h, required no write", text_waddr, text_wdata);
            end else begin
                e = exp_q.pop_front();
                if (text_waddr !== e.addr || text_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write_seq: addr=%0d data=%h, required addr=%0d data=%h",
                             text_waddr, text_wdata, e.addr, e.data);
                end
            end
        end
    end

    function automatic void exp_write(input int a, input logic [6:0] d);
        wr_t e;
        e.addr = a[5:0];
        e.data = d;
        exp_q.push_back(e);
        mscr[a] = d;
    endfunction

    function automatic void model_scroll();
        for (int i = 0; i < CELLS - COLS; i++) exp_write(i, mscr[i + COLS]);
        for (int i = CELLS - COLS; i < CELLS; i++) exp_write(i, 7'h20);
        mcur = CELLS - COLS;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < CELLS; i++) exp_write(i, 7'h20);
        mcur = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_write(mcur, b[6:0]);
            if (mcur == CELLS - 1) model_scroll();
            else mcur++;
        end else if (b == 8'h0A) begin
            if (mcur / COLS == ROWS - 1) model_scroll();
            else mcur = (mcur / COLS + 1) * COLS;
        end else if (b == 8'h0D) begin
            mcur = (mcur / COLS) * COLS;
        end else if (b == 8'h08) begin
            if (mcur > 0) mcur--;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Offer one byte, hold it until accepted; returns at accept edge + 1.
    task automatic push_byte(input logic [7:0] b);
        int   n;
        logic acc;
        n        = 0;
        acc      = 1'b0;
        wr_data  = b;
        wr_valid = 1'b1;
        while (!acc && n < 200) begin
            acc = wr_ready;
            @(posedge clk); #1;
            n++;
        end
        wr_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: byte %h not accepted in %0d cycles", b, n);
        end else begin
            model_byte(b);
        end
    endtask

    task automatic pulse_clear();
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        model_clear();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_state(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < CELLS; i++) if (ram[i] !== mscr[i]) bad++;
        chk({name, "_screen_bad_cells"}, bad, 0);
        chk({name, "_cursor"}, cursor, mcur);
        chk({name, "_writes_left"}, exp_q.size(), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = 8'h00;
        clear_req = 1'b0;
        ram_fill  = 1'b1;
        mcur      = 0;
        for (int i = 0; i < CELLS; i++) mscr[i] = 7'h00;
        repeat (3) @(posedge clk);
        #1;
        ram_fill = 1'b0;

        chk("rst_text_we", text_we, 0);
        chk("rst_text_waddr", text_waddr, 0);
        chk("rst_text_wdata", text_wdata, 0);
        chk("rst_cursor", cursor, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_busy", busy, 1);

        // 1: reset-triggered clear
        rst_n = 1'b1;
        model_clear();
        wait_idle();
        chk("t1_run_len", last_run, 36);
        chk("t1_cell35", ram[35], 7'h20);
        check_state("t1");

        // 2: write latency, CR, overwrite
        push_byte(8'h41);
        chk("t2_we_at_accept", text_we, 0);
        @(posedge clk); #1;
        chk("t2_we", text_we, 1);
        chk("t2_waddr", text_waddr, 0);
        chk("t2_wdata", text_wdata, 7'h41);
        @(posedge clk); #1;
        chk("t2_we_one_cycle", text_we, 0);
        chk("t2_cursor_after_A", cursor, 1);
        push_byte(8'h0D);
        wait_idle();
        chk("t2_cursor_after_CR", cursor, 0);
        push_byte(8'h42);
        wait_idle();
        chk("t2_cell0", ram[0], 7'h42);
        check_state("t2");

        // 3: fill whole screen back-to-back, wrap into scroll
        push_byte(8'h0D);
        for (int i = 0; i < CELLS; i++) push_byte(8'h30 + 8'(i % 10));
        wait_idle();
        chk("t3_run_len", last_run, 72);
        chk("t3_cell0", ram[0], 7'h32);
        chk("t3_cell23", ram[23], 7'h35);
        chk("t3_cell24", ram[24], 7'h20);
        chk("t3_cursor", cursor, 24);
        check_state("t3");

        // 4: LF mid-screen and LF on the last row
        pulse_clear();
        wait_idle();
        for (int i = 0; i < 5; i++) push_byte(8'h61 + 8'(i));
        push_byte(8'h0A);
        wait_idle();
        chk("t4_cursor_lf", cursor, 12);
        push_byte(8'h0A);
        for (int i = 0; i < 6; i++) push_byte(8'h6B + 8'(i));
        wait_idle();
        chk("t4_cursor_30", cursor, 30);
        push_byte(8'h0A);
        chk("t4_we_at_accept", text_we, 0);
        @(posedge clk); #1;
        chk("t4_we_at_pop", text_we, 0);
        @(posedge clk); #1;
        chk("t4_first_scroll_we", text_we, 1);
        wait_idle();
        chk("t4_run_len", last_run, 36);
        chk("t4_cursor_after_scroll", cursor, 24);
        check_state("t4");

        // 5: FIFO fills during a scroll, bytes drain in order afterwards
        push_byte(8'h0A);
        for (int i = 0; i < 4; i++) push_byte(8'h41 + 8'(i));
        chk("t5_ready_low", wr_ready, 0);
        push_byte(8'h45);
        push_byte(8'h46);
        wait_idle();
        chk("t5_cell24", ram[24], 7'h41);
        chk("t5_cell29", ram[29], 7'h46);
        chk("t5_cursor", cursor, 30);
        check_state("t5");

        // 6: BS boundaries, ignored code, clear during scroll
        pulse_clear();
        wait_idle();
        push_byte(8'h08);
        wait_idle();
        chk("t6_bs_at_0", cursor, 0);
        push_byte(8'h07);
        wait_idle();
        chk("t6_bell_ignored", cursor, 0);
        push_byte(8'h0A);
        push_byte(8'h08);
        wait_idle();
        chk("t6_bs_row_cross", cursor, 11);
        push_byte(8'h0A);
        push_byte(8'h0A);
        push_byte(8'h0A);
        repeat (5) begin @(posedge clk); #1; end
        pulse_clear();
        wait_idle();
        chk("t6_clear_run_len", last_run, 36);
        chk("t6_cursor", cursor, 0);
        check_state("t6");

        // Reset in the middle of a scroll
        push_byte(8'h0A);
        push_byte(8'h0A);
        push_byte(8'h0A);
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst2_text_we", text_we, 0);
        chk("rst2_cursor", cursor, 0);
        chk("rst2_busy", busy, 1);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        wait_idle();
        check_state("rst2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_console_writer.md
# vga_console_writer

Byte-stream front end for the VGA text console peripheral. It accepts ASCII bytes from the TinyQV register interface through a small FIFO and drives the console's text buffer write port. It manages a cursor, CR/LF/BS control codes, line wrap, hardware scroll (row copy plus clear) and full-screen clear. It sits directly upstream of the text RAM that the character renderer scans.

## Interface
Parameters:
- COLS, 12, characters per row
- ROWS, 3, rows on screen; COLS*ROWS ≤ 64
- FIFO_DEPTH, 4, input byte FIFO entries (power of two)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- wr_valid  in  1  byte offered (one CPU 8-bit write)
- wr_data  in  8  ASCII byte
- wr_ready  out  1  FIFO not full; byte accepted on clk edge when wr_valid & wr_ready
- clear_req  in  1  single-cycle pulse requesting a screen clear
- text_we  out  1  text RAM write strobe (registered)
- text_waddr  out  6  write index, row*COLS+col (registered)
- text_wdata  out  7  glyph code (registered)
- text_raddr  out  6  read index used during scroll (combinational from state)
- text_rdata  in  7  text RAM read data, combinational w.r.t. text_raddr
- cursor  out  6  current cursor index
- busy  out  1  high when state≠IDLE, FIFO non-empty, or a clear is pending

## Operation
- States: IDLE, SCROLL_COPY, SCROLL_FILL, CLEAR.
- Clear: clear_pending is set by clear_req and by reset. It is served in IDLE with priority over the FIFO. CLEAR writes 0x20 to indices 0..COLS*ROWS-1 in ascending order, one per cycle, then sets cursor=0 and returns to IDLE. FIFO contents are retained.
- IDLE with FIFO non-empty: pop one byte per cycle and decode:
  - 0x20–0x7E: write wr_data[6:0] at cursor, then advance col. If col wraps, advance row. On wrap past the last cell (index 35 by default), enter SCROLL_COPY with cursor=(ROWS-1)*COLS.
  - 0x0A (LF): col=0, row+1. On the last row, enter SCROLL_COPY with cursor=(ROWS-1)*COLS. No write.
  - 0x0D (CR): col=0. No write.
  - 0x08 (BS): if cursor>0, cursor-1, crossing to the previous row end if needed. No erase, no write.
  - All other codes: dropped, no effect.
- SCROLL_COPY: for i=0..(ROWS-1)*COLS-1, drive text_raddr=i+COLS and write text_rdata to index i. Writes land in ascending order.
- SCROLL_FILL: write 0x20 to the last row's indices in ascending order, then return to IDLE.
- clear_req during SCROLL or CLEAR: latched. The current operation completes, then CLEAR runs.
- Cursor is held internally as row/col counters. cursor = row*COLS+col and is always < COLS*ROWS.

## Timing
- Reset values:
  - Outputs: text_we=0, text_waddr=0, text_wdata=0, cursor=0, wr_ready=1, busy=1.
  - Internal: clear_pending=1, state IDLE, FIFO empty.
- Reset is applied in any state and aborts any scroll or clear. The aborted operation is superseded by the reset-triggered clear.
- Write latency:
  - A byte accepted at edge E is popped at edge E+1 (FIFO empty, IDLE).
  - Its text_we is high for exactly one cycle, E+1→E+2.
- Throughput: one printable byte per cycle sustained in IDLE.
- Scroll, default parameters:
  - 24 copy cycles plus 12 fill cycles give 36 consecutive text_we cycles.
  - First scroll write follows one cycle after the triggering char write.
- Scroll pipeline: text_raddr is driven in cycle k. text_rdata is registered into text_wdata, so the write occurs in cycle k+1.
- FIFO:
  - wr_ready depends on full only.
  - Push while full is ignored.
  - Simultaneous push and pop when not full is allowed, and count is unchanged.
- busy falls the cycle after the last text_we when the FIFO is empty and no clear is pending.

## Structure
- Shared package vga_console_pkg holds:
  - COLS/ROWS defaults
  - CHAR_SPACE=7'h20
  - ASCII_LF, ASCII_CR, ASCII_BS
  - state enum
- Sub-module console_byte_fifo: synchronous FIFO, FIFO_DEPTH×8, with push/pop/full/empty.
- Top-level: decoder, cursor counters, FSM and output registers.

## Test plan
1. Release reset → 36 text_we pulses, addr 0..35, data 0x20, cursor=0. busy then drops.
2. Send 0x41 → text_we addr 0 data 0x41 two cycles after accept, cursor=1. Send 0x0D → cursor=0. Send 0x42 → addr 0 data 0x42.
3. Send 36 bytes 0x30+(i%10) → last char written at addr 35. Then addr i receives old value of i+12 for i=0..23, addr 24..35 receive 0x20, and cursor=24.
4. At cursor 5, send 0x0A → cursor=12, no write. At cursor 30, send 0x0A → scroll of 36 writes, cursor=24.
5. Push 6 bytes back-to-back during a scroll → wr_ready low after 4 accepted. Bytes are written in order after the scroll completes, with no loss or duplication.
6. 0x08 at cursor 0 → cursor stays 0. 0x07 → ignored. clear_req mid-scroll → scroll completes, then 36 writes of 0x20, cursor=0.
